// File: rtl/wishbone_pkg.sv
// Shared Wishbone definitions: bus widths and the arbiter FSM state encoding.
// The FSM has only two states, so busy_o is the debug view of the state.
package wishbone_pkg;

  localparam int WB_DATA_NBITS = 32;
  localparam int WB_ADR_NBITS  = 32;
  localparam int WB_SEL_NBITS  = WB_DATA_NBITS / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arb_round_robin.sv
// Combinational round-robin priority encoder: picks the first set request
// at or above rr_ptr, wrapping modulo p_num_masters.
module arb_round_robin #(
  parameter  int p_num_masters = 2,
  localparam int c_idx_nbits   = $clog2(p_num_masters)
) (
  input  logic [p_num_masters-1:0] req,
  input  logic [c_idx_nbits-1:0]   rr_ptr,
  output logic [c_idx_nbits-1:0]   grant,
  output logic                     any_req
);

  int idx;

  always_comb begin
    grant   = rr_ptr;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < p_num_masters; k++) begin
      // rr_ptr is always < p_num_masters, so a single subtraction wraps.
      idx = int'(rr_ptr) + k;
      if (idx >= p_num_masters) begin
        idx = idx - p_num_masters;
      end
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = c_idx_nbits'(idx);
      end
    end
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among p_num_masters masters,
// with burst locking on cyc and a per-beat stall watchdog that returns err.
module wishbone_arbiter
  import wishbone_pkg::*;
#(
  parameter  int p_num_masters    = 2,
  parameter  int p_timeout_cycles = 16,
  localparam int c_idx_nbits      = $clog2(p_num_masters),
  localparam int c_cnt_nbits      = (p_timeout_cycles > 0) ? $clog2(p_timeout_cycles + 1) : 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [p_num_masters-1:0]                      m_cyc_i,
  input  logic [p_num_masters-1:0]                      m_stb_i,
  input  logic [p_num_masters-1:0]                      m_we_i,
  input  logic [p_num_masters-1:0][WB_SEL_NBITS-1:0]    m_sel_i,
  input  logic [p_num_masters-1:0][WB_ADR_NBITS-1:0]    m_adr_i,
  input  logic [p_num_masters-1:0][WB_DATA_NBITS-1:0]   m_dat_i,
  output logic [p_num_masters-1:0]                      m_ack_o,
  output logic [p_num_masters-1:0]                      m_err_o,
  output logic [p_num_masters-1:0][WB_DATA_NBITS-1:0]   m_dat_o,
  output logic                                          s_cyc_o,
  output logic                                          s_stb_o,
  output logic                                          s_we_o,
  output logic [WB_SEL_NBITS-1:0]                       s_sel_o,
  output logic [WB_ADR_NBITS-1:0]                       s_adr_o,
  output logic [WB_DATA_NBITS-1:0]                      s_dat_o,
  input  logic                                          s_ack_i,
  input  logic [WB_DATA_NBITS-1:0]                      s_dat_i,
  output logic [c_idx_nbits-1:0]                        grant_o,
  output logic                                          busy_o
);

  localparam bit                     c_wd_en   = (p_timeout_cycles > 0);
  localparam logic [c_cnt_nbits-1:0] c_wd_term =
    c_cnt_nbits'((p_timeout_cycles > 0) ? (p_timeout_cycles - 1) : 0);
  localparam logic [c_idx_nbits-1:0] c_last_idx = c_idx_nbits'(p_num_masters - 1);

  arb_state_t               state;
  logic [c_idx_nbits-1:0]   grant;
  logic [c_idx_nbits-1:0]   rr_ptr;
  logic [c_cnt_nbits-1:0]   wd_cnt;
  logic                     err_q;

  logic [p_num_masters-1:0] req;
  logic [c_idx_nbits-1:0]   arb_grant;
  logic                     arb_any;
  logic [c_idx_nbits-1:0]   next_ptr;
  logic                     stall;
  logic                     wd_fire;

  assign req = m_cyc_i & m_stb_i;

  arb_round_robin #(
    .p_num_masters (p_num_masters)
  ) u_rr (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  assign next_ptr = (grant == c_last_idx) ? '0 : grant + c_idx_nbits'(1);

  // A stalled beat is a presented strobe the slave has not acknowledged.
  assign stall   = (state == BUSY) && s_stb_o && !s_ack_i;
  assign wd_fire = c_wd_en && stall && (wd_cnt == c_wd_term);

  assign grant_o = grant;
  assign busy_o  = (state == BUSY);

  // Slave side: the owner's signals pass straight through; the strobe is
  // suppressed during the error cycle so the slave sees the beat abandoned.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (state == BUSY) begin
      s_cyc_o = m_cyc_i[grant];
      s_stb_o = m_stb_i[grant] & ~err_q;
      s_we_o  = m_we_i[grant];
      s_sel_o = m_sel_i[grant];
      s_adr_o = m_adr_i[grant];
      s_dat_o = m_dat_i[grant];
    end
  end

  // Master side: only the owner sees responses; everyone else reads zeros.
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = '0;
    if (state == BUSY) begin
      m_ack_o[grant] = s_ack_i & s_stb_o;
      m_err_o[grant] = err_q;
      m_dat_o[grant] = s_dat_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          err_q  <= 1'b0;
          if (arb_any) begin
            grant <= arb_grant;
            state <= BUSY;
          end
        end
        BUSY: begin
          // The grant stays locked while the owner holds cyc, even with stb low.
          if (!m_cyc_i[grant]) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
            wd_cnt <= '0;
            err_q  <= 1'b0;
          end else begin
            err_q <= wd_fire;
            if (!c_wd_en || !stall || wd_fire) begin
              wd_cnt <= '0;
            end else begin
              wd_cnt <= wd_cnt + c_cnt_nbits'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter: arbitration order, burst lock, stall
// watchdog, ack-vs-timeout race and asynchronous reset, with a data scoreboard.
module tb_wishbone_arbiter;

  localparam int N = 2;
  localparam int T = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          m_cyc_i;
  logic [N-1:0]          m_stb_i;
  logic [N-1:0]          m_we_i;
  logic [N-1:0][3:0]     m_sel_i;
  logic [N-1:0][31:0]    m_adr_i;
  logic [N-1:0][31:0]    m_dat_i;
  logic [N-1:0]          m_ack_o;
  logic [N-1:0]          m_err_o;
  logic [N-1:0][31:0]    m_dat_o;
  logic                  s_cyc_o;
  logic                  s_stb_o;
  logic                  s_we_o;
  logic [3:0]            s_sel_o;
  logic [31:0]           s_adr_o;
  logic [31:0]           s_dat_o;
  logic                  s_ack_i;
  logic [31:0]           s_dat_i;
  logic [0:0]            grant_o;
  logic                  busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] wr_q[$];
  logic [31:0] rd_q[$];

  wishbone_arbiter #(
    .p_num_masters    (N),
    .p_timeout_cycles (T)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_sel_i (m_sel_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_dat_o (m_dat_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_sel_o (s_sel_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_ack_i (s_ack_i),
    .s_dat_i (s_dat_i),
    .grant_o (grant_o),
    .busy_o  (busy_o)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation did not finish within time budget");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_master(input int i, input logic cyc, input logic stb,
                              input logic we, input logic [31:0] adr,
                              input logic [31:0] dat);
    m_cyc_i[i] = cyc;
    m_stb_i[i] = stb;
    m_we_i[i]  = we;
    m_sel_i[i] = 4'hF;
    m_adr_i[i] = adr;
    m_dat_i[i] = dat;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop expected write beats when the slave acks a write.
  task automatic observe_write(input string tag);
    logic [63:0] exp;
    if (s_stb_o && s_ack_i && s_we_o) begin
      check({tag, "_q_nonempty"}, 64'(wr_q.size() > 0), 64'd1);
      exp = (wr_q.size() > 0) ? wr_q.pop_front() : 64'd0;
      check(tag, {s_adr_o, s_dat_o}, exp);
    end
  endtask

  // Scoreboard: pop expected read data when master g receives an ack.
  task automatic observe_read(input string tag, input int g);
    logic [31:0] exp;
    if (m_ack_o[g]) begin
      check({tag, "_q_nonempty"}, 64'(rd_q.size() > 0), 64'd1);
      exp = (rd_q.size() > 0) ? rd_q.pop_front() : 32'd0;
      check(tag, 64'(m_dat_o[g]), 64'(exp));
    end
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_s_ctl"}, {s_cyc_o, s_stb_o, s_we_o, s_sel_o}, 64'd0);
    check({tag, "_s_adr_dat"}, {s_adr_o, s_dat_o}, 64'd0);
    check({tag, "_m_ack_err"}, {m_ack_o, m_err_o}, 64'd0);
    check({tag, "_m_dat"}, 64'(m_dat_o), 64'd0);
    check({tag, "_busy_grant"}, {busy_o, grant_o}, 64'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    settle();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    m_cyc_i = '0;
    m_stb_i = '0;
    m_we_i  = '0;
    m_sel_i = '0;
    m_adr_i = '0;
    m_dat_i = '0;
    s_ack_i = 1'b0;
    s_dat_i = '0;
    tick();
    tick();

    // Reset state
    check_all_quiet("rst");
    reset = 1'b1;
    tick();

    // Single write from master 0, slave acks immediately
    drive_master(0, 1'b1, 1'b1, 1'b1, 32'h3000_0004, 32'hDEAD_BEEF);
    wr_q.push_back({32'h3000_0004, 32'hDEAD_BEEF});
    settle();
    check("t1_latency_stb", 64'(s_stb_o), 64'd0);
    check("t1_latency_busy", 64'(busy_o), 64'd0);
    tick();
    s_ack_i = 1'b1;
    settle();
    check("t1_stb", 64'(s_stb_o), 64'd1);
    check("t1_grant", 64'(grant_o), 64'd0);
    check("t1_busy", 64'(busy_o), 64'd1);
    check("t1_ack", 64'(m_ack_o), 64'b01);
    check("t1_we_sel", {s_we_o, s_sel_o}, 64'h1F);
    observe_write("t1_wr");
    tick();
    drive_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_ack_i = 1'b0;
    settle();
    check("t1_dropped_stb", 64'(s_stb_o), 64'd0);
    tick();
    settle();
    check("t1_idle", 64'(busy_o), 64'd0);

    // Contention from reset: master 0 first, then round robin
    apply_reset();
    drive_master(0, 1'b1, 1'b1, 1'b0, 32'h3000_0100, 32'h0);
    drive_master(1, 1'b1, 1'b1, 1'b0, 32'h3000_0200, 32'h0);
    settle();
    check("t2_pre_busy", 64'(busy_o), 64'd0);
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h1111_2222;
    rd_q.push_back(32'h1111_2222);
    settle();
    check("t2_first_grant", 64'(grant_o), 64'd0);
    check("t2_first_ack", 64'(m_ack_o), 64'b01);
    check("t2_first_adr", 64'(s_adr_o), 64'h3000_0100);
    check("t2_nonowner_dat", 64'(m_dat_o[1]), 64'd0);
    observe_read("t2_rd0", 0);
    tick();
    drive_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_ack_i = 1'b0;
    settle();
    tick();
    settle();
    check("t2_gap_busy", 64'(busy_o), 64'd0);
    check("t2_gap_stb", 64'(s_stb_o), 64'd0);
    drive_master(0, 1'b1, 1'b1, 1'b0, 32'h3000_0100, 32'h0);
    tick();
    settle();
    check("t2_rr_grant1", 64'(grant_o), 64'd1);
    check("t2_rr_adr", 64'(s_adr_o), 64'h3000_0200);
    drive_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    settle();
    check("t2_gap2_busy", 64'(busy_o), 64'd0);
    tick();
    settle();
    check("t2_m0_again", {busy_o, grant_o}, 64'b10);
    drive_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    settle();
    check("t2_end_idle", 64'(busy_o), 64'd0);

    // Three-beat read burst on master 1 with master 0 pending
    drive_master(1, 1'b1, 1'b1, 1'b0, 32'h3000_0010, 32'h0);
    drive_master(0, 1'b1, 1'b1, 1'b0, 32'h3000_0300, 32'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      m_adr_i[1] = 32'h3000_0010 + 32'(4 * k);
      m_stb_i[1] = 1'b1;
      s_ack_i    = 1'b1;
      s_dat_i    = $urandom;
      rd_q.push_back(s_dat_i);
      settle();
      check("t3_grant", 64'(grant_o), 64'd1);
      check("t3_adr", 64'(s_adr_o), 64'(32'h3000_0010 + 32'(4 * k)));
      check("t3_ack", 64'(m_ack_o), 64'b10);
      check("t3_m0_quiet", {m_err_o[0], m_dat_o[0]}, 64'd0);
      observe_read("t3_rd1", 1);
      tick();
      m_stb_i[1] = 1'b0;
      s_ack_i    = 1'b0;
      settle();
      check("t3_lock_grant", {busy_o, grant_o}, 64'b11);
      check("t3_lock_stb_ack", {s_stb_o, m_ack_o}, 64'd0);
      tick();
    end
    drive_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    settle();
    check("t3_release", 64'(busy_o), 64'd0);
    tick();

    // Watchdog: master 0 stalls, slave never acks
    for (int n = 1; n <= T; n++) begin
      settle();
      check("t4_stall_stb", 64'(s_stb_o), 64'd1);
      check("t4_stall_err", 64'(m_err_o), 64'd0);
      check("t4_stall_grant", 64'(grant_o), 64'd0);
      tick();
    end
    settle();
    check("t4_err_pulse", 64'(m_err_o), 64'b01);
    check("t4_err_stb", 64'(s_stb_o), 64'd0);
    check("t4_err_ack", 64'(m_ack_o), 64'd0);
    check("t4_err_busy", 64'(busy_o), 64'd1);
    tick();
    settle();
    check("t4_err_once", 64'(m_err_o), 64'd0);
    check("t4_stb_back", 64'(s_stb_o), 64'd1);
    drive_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    settle();
    check("t4_busy_after", 64'(busy_o), 64'd0);

    // Ack on the terminal-count cycle wins over the watchdog
    drive_master(0, 1'b1, 1'b1, 1'b0, 32'h3000_0500, 32'h0);
    tick();
    for (int n = 1; n < T; n++) begin
      settle();
      check("t5_stall_err", 64'(m_err_o), 64'd0);
      tick();
    end
    s_ack_i = 1'b1;
    s_dat_i = 32'hA5A5_5A5A;
    rd_q.push_back(32'hA5A5_5A5A);
    settle();
    check("t5_term_ack", 64'(m_ack_o), 64'b01);
    check("t5_term_err", 64'(m_err_o), 64'd0);
    observe_read("t5_rd0", 0);
    tick();
    s_ack_i = 1'b0;
    settle();
    check("t5_no_err", 64'(m_err_o), 64'd0);
    check("t5_stb_kept", 64'(s_stb_o), 64'd1);
    drive_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    settle();
    check("t5_idle", 64'(busy_o), 64'd0);

    // Asynchronous reset in the middle of a master 1 burst
    drive_master(1, 1'b1, 1'b1, 1'b0, 32'h3000_0600, 32'h0);
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h0000_0077;
    rd_q.push_back(32'h0000_0077);
    settle();
    check("t6_pre_grant", 64'(grant_o), 64'd1);
    check("t6_pre_ack", 64'(m_ack_o), 64'b10);
    observe_read("t6_rd1", 1);
    reset = 1'b0;
    settle();
    check_all_quiet("t6_async");
    tick();
    check_all_quiet("t6_held");
    reset = 1'b1;
    s_ack_i = 1'b0;
    drive_master(0, 1'b1, 1'b1, 1'b0, 32'h3000_0700, 32'h0);
    settle();
    tick();
    settle();
    check("t6_rr_after_reset", {busy_o, grant_o}, 64'b10);
    drive_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    settle();
    check("t6_end_idle", 64'(busy_o), 64'd0);

    // Every expected transfer must have been observed
    check("sb_wr_drained", 64'(wr_q.size()), 64'd0);
    check("sb_rd_drained", 64'(rd_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter.md
Name: wishbone_arbiter

Overview:
- Shares one Wishbone slave port (the stream bridge's wbs_* interface) among p_num_masters Wishbone masters, e.g. management core plus on-chip DMA/test masters.
- Round-robin grant with a registered grant decision.
- The grant is locked for the whole cyc burst.
- A per-cycle stall watchdog returns a Wishbone error if the slave never acks.

Parameters:
p_num_masters, 2, number of requesting masters (>=2)
p_timeout_cycles, 16, cycles of stb without ack before error; 0 disables the watchdog
c_idx_nbits, $clog2(p_num_masters), local width of the grant index (not set from outside)
c_cnt_nbits, $clog2(p_timeout_cycles+1), local watchdog counter width (not set from outside)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
m_cyc_i  input  1 [p_num_masters]  per-master cycle
m_stb_i  input  1 [p_num_masters]  per-master strobe
m_we_i  input  1 [p_num_masters]  per-master write enable
m_sel_i  input  4 [p_num_masters]  per-master byte select
m_adr_i  input  32 [p_num_masters]  per-master address
m_dat_i  input  32 [p_num_masters]  per-master write data
m_ack_o  output  1 [p_num_masters]  per-master ack
m_err_o  output  1 [p_num_masters]  per-master error (watchdog)
m_dat_o  output  32 [p_num_masters]  per-master read data
s_cyc_o  output  1  to slave (wbs_cyc_i)
s_stb_o  output  1  to slave (wbs_stb_i)
s_we_o  output  1  to slave (wbs_we_i)
s_sel_o  output  4  to slave (wbs_sel_i)
s_adr_o  output  32  to slave (wbs_adr_i)
s_dat_o  output  32  to slave (wbs_dat_i)
s_ack_i  input  1  from slave (wbs_ack_o)
s_dat_i  input  32  from slave (wbs_dat_o)
grant_o  output  c_idx_nbits  current owner index
busy_o  output  1  bus owned

Behaviour:
- Reset (reset=0, async):
  - State IDLE, rr_ptr=0, grant=0, watchdog=0.
  - All s_* outputs 0, all m_ack_o/m_err_o/m_dat_o 0, busy_o=0, grant_o=0.
  - Reset mid-burst drops the burst silently; no ack or err is issued.
- FSM states are IDLE and BUSY.
- IDLE:
  - req[i] = m_cyc_i[i] & m_stb_i[i].
  - If any req is set, register grant = first i with req[i] set, scanning from rr_ptr upward with wrap modulo p_num_masters; next state is BUSY.
  - s_* outputs are all 0 in IDLE. Latency is 1: a request at edge t produces s_stb_o at t+1.
- BUSY (owner g = grant):
  - busy_o=1.
  - s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o equal master g's inputs, combinationally.
  - m_ack_o[g] = s_ack_i & s_stb_o and m_dat_o[g] = s_dat_i, combinationally.
  - Every non-owner sees ack=0, err=0, dat=0.
  - The grant holds while m_cyc_i[g]=1, including cycles with stb low (burst lock).
  - When m_cyc_i[g]=0 the next state is IDLE and rr_ptr = (g+1) mod p_num_masters.
  - Re-arbitration takes one IDLE cycle, so back-to-back owners are separated by >=1 idle cycle.
- Watchdog (p_timeout_cycles>0):
  - Counts BUSY cycles with s_stb_o=1 and s_ack_i=0.
  - Clears on ack, on stb low and on leaving BUSY.
  - When the count equals p_timeout_cycles-1 with no ack that cycle:
    - the next cycle asserts m_err_o[g]=1 for exactly one cycle;
    - s_stb_o is forced 0 that cycle;
    - the counter is cleared.
  - The grant is retained; the master must drop cyc to release.
  - An ack arriving in the same cycle as the terminal count wins: ack is passed, no err.
- Simultaneous requests: the lowest index at or above rr_ptr wins, so starvation is bounded by p_num_masters bursts.
- A requester dropping cyc in the same cycle it would be granted is still granted. The next cycle sees cyc=0 and returns to IDLE with no slave strobe beyond that one BUSY cycle (s_stb_o=0).

Decomposition:
- Shared package (wishbone_pkg): the FSM state enum {IDLE, BUSY} and the localparam WB_DATA_NBITS=32.
- One sub-module, arb_round_robin: a combinational round-robin priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant index, any_req.
- The FSM, watchdog and mux live in wishbone_arbiter.

Test Plan:
- Single master 0 writes adr 0x3000_0004 data 0xDEAD_BEEF, slave acks in the same cycle → s_stb_o rises 1 cycle after request; m_ack_o[0]=1; m_ack_o[1]=0; grant_o=0.
- Masters 0 and 1 request together from reset → master 0 served first; after it drops cyc there is 1 idle cycle, then master 1 is granted; a repeated contention then grants master 1 before master 0 (rr_ptr=1).
- Master 1 holds cyc for a 3-beat read burst at 0x3000_0010/14/18 → no grant change; m_dat_o[1] tracks s_dat_i on each ack; master 0 request pending throughout sees only 0s.
- Slave never acks, p_timeout_cycles=16 → m_err_o[g] pulses exactly once at cycle 17 of the stall with s_stb_o=0 that cycle; after the master drops cyc, busy_o=0.
- Ack arrives on the same cycle as the terminal count → ack delivered, m_err_o stays 0.
- reset pulled low mid-burst → all outputs 0 immediately (async); after release, the first requester arbitration starts with rr_ptr=0.
